mcp_load_sequencer: RTL and testbench



---
 rtl/mcp_pkg.sv | 24 ++
 rtl/mcp_down_counter.sv | 34 +++
 rtl/mcp_load_sequencer.sv | 130 +++++++++++++
 tb/tb_mcp_load_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mcp_pkg.sv
// Shared definitions for the multicycle-path load sequencer and its register wrapper.
package mcp_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StDrain  = 2'd2
    } mcp_state_e;

    localparam int unsigned MaxWidth = 256;

    // Repeating 2'b10 pattern for the low w bits; bits at and above w are zero.
    function automatic logic [MaxWidth-1:0] reset_pattern(input int unsigned w);
        logic [MaxWidth-1:0] pat;
        pat = '0;
        for (int i = 0; i < MaxWidth; i++) begin
            if (i < w) begin
                pat[i] = (i % 2) == 1;
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/mcp_down_counter.sv
// Loadable down counter that saturates at zero; shared by the settle and drain phases.
module mcp_down_counter #(
    parameter int unsigned cnt_width = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 load_i,
    input  logic [cnt_width-1:0] load_val_i,
    input  logic                 dec_i,
    output logic                 zero_o
);

    logic [cnt_width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mcp_load_sequencer.sv
// Drives SET/val of a multicycle-path register: holds val for `cycles` edges, strobes SET,
// then waits `dst_cycles` for the destination to settle before flagging VALID.
module mcp_load_sequencer
    import mcp_pkg::*;
#(
    parameter int unsigned width      = 1,
    parameter int unsigned cycles     = 2,
    parameter int unsigned dst_cycles = 1,
    parameter int unsigned cnt_width  = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             ENQ,
    input  logic [width-1:0] ENQ_DATA,
    input  logic             ABORT,
    output logic             RDY,
    output logic [width-1:0] val,
    output logic             SET,
    output logic             VALID,
    output logic             DONE
);

    localparam longint unsigned CntRange = 64'd1 << cnt_width;

    if (cycles == 0 || cycles > CntRange || dst_cycles > CntRange - 1 || width == 0 ||
        width > MaxWidth) begin : gen_param_check
        $error("mcp_load_sequencer: parameter out of range");
    end

    localparam logic [MaxWidth-1:0]  RstPattern  = reset_pattern(width);
    localparam logic [width-1:0]     ValRst      = RstPattern[width-1:0];
    localparam logic [cnt_width-1:0] SettleLoad  = cnt_width'(cycles - 1);
    localparam logic [cnt_width-1:0] DrainLoad   = cnt_width'((dst_cycles == 0) ? 0 : dst_cycles - 1);

    mcp_state_e state_q, state_d;
    logic [width-1:0] val_q, val_d;
    logic valid_q, valid_d;
    logic done_q, done_d;

    logic             cnt_load;
    logic [cnt_width-1:0] cnt_load_val;
    logic             cnt_dec;
    logic             cnt_zero;
    logic             set_w;

    mcp_down_counter #(
        .cnt_width (cnt_width)
    ) u_counter (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Gated by RST_N so the synchronous reset cycle never strobes the register.
    assign set_w = RST_N && (state_q == StSettle) && cnt_zero && !ABORT;

    always_comb begin
        state_d      = state_q;
        val_d        = val_q;
        valid_d      = valid_q;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = SettleLoad;
        cnt_dec      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ENQ) begin
                    val_d        = ENQ_DATA;
                    cnt_load     = 1'b1;
                    cnt_load_val = SettleLoad;
                    state_d      = StSettle;
                end
            end
            StSettle: begin
                if (ABORT) begin
                    state_d = StIdle;
                end else if (cnt_zero) begin
                    valid_d = 1'b0;
                    if (dst_cycles == 0) begin
                        valid_d = 1'b1;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_load     = 1'b1;
                        cnt_load_val = DrainLoad;
                        state_d      = StDrain;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            StDrain: begin
                if (cnt_zero) begin
                    valid_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= StIdle;
            val_q   <= ValRst;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign RDY   = (state_q == StIdle);
    assign val   = val_q;
    assign SET   = set_w;
    assign VALID = valid_q;
    assign DONE  = done_q;

endmodule

// File: tb/tb_mcp_load_sequencer.sv
// Directed bench: a 3/2 sequencer and a 1/0 corner instance, each with a downstream register model.
module tb_mcp_load_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N;

    logic       enq_a, abort_a;
    logic [7:0] data_a;
    logic       rdy_a, set_a, valid_a, done_a;
    logic [7:0] val_a;

    logic       enq_b, abort_b;
    logic [7:0] data_b;
    logic       rdy_b, set_b, valid_b, done_b;
    logic [7:0] val_b;

    logic [7:0] get_a = 8'hAA;
    logic [7:0] get_b = 8'hAA;
    int         sets_a = 0;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    mcp_load_sequencer #(
        .width      (8),
        .cycles     (3),
        .dst_cycles (2),
        .cnt_width  (8)
    ) u_dut_a (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ENQ      (enq_a),
        .ENQ_DATA (data_a),
        .ABORT    (abort_a),
        .RDY      (rdy_a),
        .val      (val_a),
        .SET      (set_a),
        .VALID    (valid_a),
        .DONE     (done_a)
    );

    mcp_load_sequencer #(
        .width      (8),
        .cycles     (1),
        .dst_cycles (0),
        .cnt_width  (8)
    ) u_dut_b (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .ENQ      (enq_b),
        .ENQ_DATA (data_b),
        .ABORT    (abort_b),
        .RDY      (rdy_b),
        .val      (val_b),
        .SET      (set_b),
        .VALID    (valid_b),
        .DONE     (done_b)
    );

    // Downstream multicycle registers: sample val on SET, no reset after time 0.
    always @(posedge CLK) begin
        if (set_a) begin
            get_a  <= val_a;
            sets_a <= sets_a + 1;
        end
        if (set_b) begin
            get_b <= val_b;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST_N   = 1'b0;
        enq_a   = 1'b0;
        abort_a = 1'b0;
        data_a  = 8'h00;
        enq_b   = 1'b0;
        abort_b = 1'b0;
        data_b  = 8'h00;

        // Reset
        tick();
        tick();
        #1;
        chk("rst_rdy", 32'(rdy_a), 32'd1);
        chk("rst_set", 32'(set_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_val", 32'(val_a), 32'hAA);
        chk("rst_val_b", 32'(val_b), 32'hAA);
        RST_N = 1'b1;
        tick();

        // Single load of 5C
        enq_a  = 1'b1;
        data_a = 8'h5C;
        tick();                                     // E0
        enq_a = 1'b0;
        #1;
        chk("t2_val_e0", 32'(val_a), 32'h5C);
        chk("t2_rdy_e0", 32'(rdy_a), 32'd0);
        chk("t2_set_e0", 32'(set_a), 32'd0);
        tick();                                     // E0+1
        chk("t2_set_e1", 32'(set_a), 32'd0);
        chk("t2_rdy_e1", 32'(rdy_a), 32'd0);
        tick();                                     // E0+2
        chk("t2_set_e2", 32'(set_a), 32'd1);
        tick();                                     // E0+3
        chk("t2_set_e3", 32'(set_a), 32'd0);
        chk("t2_get_e3", 32'(get_a), 32'h5C);
        chk("t2_sets_e3", 32'(sets_a), 32'd1);
        chk("t2_valid_e3", 32'(valid_a), 32'd0);
        tick();                                     // E0+4
        chk("t2_rdy_e4", 32'(rdy_a), 32'd0);
        chk("t2_valid_e4", 32'(valid_a), 32'd0);
        chk("t2_done_e4", 32'(done_a), 32'd0);
        tick();                                     // E0+5
        chk("t2_valid_e5", 32'(valid_a), 32'd1);
        chk("t2_done_e5", 32'(done_a), 32'd1);
        chk("t2_rdy_e5", 32'(rdy_a), 32'd1);
        tick();                                     // E0+6
        chk("t2_done_e6", 32'(done_a), 32'd0);
        chk("t2_valid_e6", 32'(valid_a), 32'd1);

        // ENQ during SETTLE is ignored
        enq_a  = 1'b1;
        data_a = 8'h44;
        tick();                                     // E0
        data_a = 8'h33;
        tick();                                     // E0+1
        chk("t3_val_busy", 32'(val_a), 32'h44);
        chk("t3_rdy_busy", 32'(rdy_a), 32'd0);
        tick();                                     // E0+2
        enq_a = 1'b0;
        chk("t3_set_e2", 32'(set_a), 32'd1);
        tick();                                     // E0+3
        chk("t3_valid_e3", 32'(valid_a), 32'd0);
        chk("t3_get_e3", 32'(get_a), 32'h44);
        tick();                                     // E0+4
        tick();                                     // E0+5
        chk("t3_valid_e5", 32'(valid_a), 32'd1);
        chk("t3_sets_e5", 32'(sets_a), 32'd2);
        chk("t3_val_e5", 32'(val_a), 32'h44);

        // ABORT in the count==0 cycle
        enq_a  = 1'b1;
        data_a = 8'h66;
        tick();                                     // E0
        enq_a = 1'b0;
        tick();                                     // E0+1
        tick();                                     // E0+2
        abort_a = 1'b1;
        #1;
        chk("t3_abort_set", 32'(set_a), 32'd0);
        tick();                                     // E0+3
        abort_a = 1'b0;
        chk("t3_abort_rdy", 32'(rdy_a), 32'd1);
        chk("t3_abort_valid", 32'(valid_a), 32'd1);
        chk("t3_abort_done", 32'(done_a), 32'd0);
        chk("t3_abort_sets", 32'(sets_a), 32'd2);
        chk("t3_abort_val", 32'(val_a), 32'h66);
        chk("t3_abort_get", 32'(get_a), 32'h44);

        // Back-to-back with ENQ held high
        enq_a  = 1'b1;
        data_a = 8'h11;
        tick();                                     // E0
        data_a = 8'h22;
        tick();                                     // E0+1
        tick();                                     // E0+2
        tick();                                     // E0+3
        tick();                                     // E0+4
        chk("t4_rdy_e4", 32'(rdy_a), 32'd0);
        tick();                                     // E0+5
        chk("t4_rdy_e5", 32'(rdy_a), 32'd1);
        chk("t4_valid_e5", 32'(valid_a), 32'd1);
        chk("t4_val_e5", 32'(val_a), 32'h11);
        chk("t4_get_e5", 32'(get_a), 32'h11);
        tick();                                     // E0+6: second word accepted
        enq_a = 1'b0;
        chk("t4_rdy_e6", 32'(rdy_a), 32'd0);
        chk("t4_val_e6", 32'(val_a), 32'h22);
        tick();                                     // E0+7
        tick();                                     // E0+8
        chk("t4_set_e8", 32'(set_a), 32'd1);
        chk("t4_valid_e8", 32'(valid_a), 32'd1);
        tick();                                     // E0+9
        chk("t4_valid_e9", 32'(valid_a), 32'd0);
        chk("t4_get_e9", 32'(get_a), 32'h22);
        tick();                                     // E0+10
        chk("t4_valid_e10", 32'(valid_a), 32'd0);
        tick();                                     // E0+11
        chk("t4_valid_e11", 32'(valid_a), 32'd1);
        chk("t4_done_e11", 32'(done_a), 32'd1);

        // Reset in the count==0 cycle of SETTLE
        enq_a  = 1'b1;
        data_a = 8'h77;
        tick();                                     // E0
        enq_a = 1'b0;
        tick();                                     // E0+1
        tick();                                     // E0+2
        RST_N = 1'b0;
        #1;
        chk("t5_set_rst", 32'(set_a), 32'd0);
        tick();                                     // E0+3
        RST_N = 1'b1;
        chk("t5_val", 32'(val_a), 32'hAA);
        chk("t5_valid", 32'(valid_a), 32'd0);
        chk("t5_rdy", 32'(rdy_a), 32'd1);
        chk("t5_get", 32'(get_a), 32'h22);
        chk("t5_sets", 32'(sets_a), 32'd4);

        // cycles=1, dst_cycles=0
        enq_b  = 1'b1;
        data_b = 8'hF0;
        tick();                                     // E0
        enq_b = 1'b0;
        #1;
        chk("t6_set_e0", 32'(set_b), 32'd1);
        chk("t6_rdy_e0", 32'(rdy_b), 32'd0);
        chk("t6_val_e0", 32'(val_b), 32'hF0);
        tick();                                     // E0+1
        chk("t6_valid_e1", 32'(valid_b), 32'd1);
        chk("t6_done_e1", 32'(done_b), 32'd1);
        chk("t6_rdy_e1", 32'(rdy_b), 32'd1);
        chk("t6_set_e1", 32'(set_b), 32'd0);
        chk("t6_get_e1", 32'(get_b), 32'hF0);
        tick();                                     // E0+2
        chk("t6_done_e2", 32'(done_b), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
